// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding an IF/ID register.
// An IF/ID slot plus a one-entry skid register form a two-instruction buffer, so a
// completed fetch is never lost while decode is stalled. Redirects discard in-flight
// data; a request already on the bus is allowed to finish and its data is dropped.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrop
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_addr;
  logic        r_skid_valid;
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_if_valid;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_ack;
  logic        w_slot_free;
  logic [63:0] w_pc_inc;
  logic [63:0] w_redirect_pc;
  logic        w_unused_rpc_lsb;

  // Request is gated by reset_n so it drops the instant reset asserts, and rises in
  // the very first cycle after release (state already sits in StFetch).
  assign imem_req         = reset_n & (r_state != StWait);
  assign imem_addr        = r_req_addr;
  assign w_ack            = imem_req & imem_ack;
  assign w_slot_free      = ~r_if_valid | id_ready;
  assign w_pc_inc         = r_pc + 64'd4;  // wraps modulo 2^64 by width
  assign w_redirect_pc    = {redirect_pc[63:2], 2'b00};
  assign w_unused_rpc_lsb = ^redirect_pc[1:0];

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

  // Fetch FSM, PC, request address, skid and IF/ID register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 64'h0;
      r_skid_instr <= 32'h0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 64'h0;
      r_if_instr   <= 32'h0;
    end else if (redirect) begin
      // Redirect wins over every other event: flush both buffer entries.
      r_if_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_pc         <= w_redirect_pc;
      unique case (r_state)
        StFetch: begin
          if (w_ack) begin
            // Request finished this edge; its data is discarded, start at the target.
            r_req_addr <= w_redirect_pc;
          end else begin
            // Request still on the bus; let it finish at the stale address.
            r_state <= StDrop;
          end
        end
        StWait: begin
          r_state    <= StFetch;
          r_req_addr <= w_redirect_pc;
        end
        StDrop: begin
          // Stale request still outstanding; only the target PC moves.
        end
        default: r_state <= StFetch;
      endcase
    end else begin
      unique case (r_state)
        StFetch: begin
          if (w_ack) begin
            r_pc <= w_pc_inc;
            if (w_slot_free) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_req_addr;
              r_if_instr <= imem_rdata;
              r_req_addr <= w_pc_inc;
            end else begin
              // Decode stalled with a full slot: park the word and stop requesting.
              r_skid_valid <= 1'b1;
              r_skid_pc    <= r_req_addr;
              r_skid_instr <= imem_rdata;
              r_state      <= StWait;
            end
          end else if (id_ready) begin
            r_if_valid <= 1'b0;
          end
        end
        StWait: begin
          if (id_ready) begin
            r_if_valid   <= 1'b1;
            r_if_pc      <= r_skid_pc;
            r_if_instr   <= r_skid_instr;
            r_skid_valid <= 1'b0;
            r_req_addr   <= r_pc;
            r_state      <= StFetch;
          end
        end
        StDrop: begin
          if (w_ack) begin
            r_req_addr <= r_pc;
            r_state    <= StFetch;
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a FIFO-level behavioural model.
module tb_instr_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B9;
    return w ^ a[63:32] ^ 32'h5A00_00A5;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- behavioural model ----------------
  // Delivered-but-unconsumed instructions form a FIFO of at most two entries; the
  // head is what IF/ID must show. A new fetch is requested whenever the FIFO has room,
  // or while a stale (pre-redirect) request is still being drained.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_buf[$];
  logic [63:0] m_pc;
  logic [63:0] m_stale;
  bit          m_drop;

  function automatic bit m_req();
    return reset_n && (m_drop || (m_buf.size() < 2));
  endfunction

  function automatic logic [63:0] m_addr();
    return m_drop ? m_stale : m_pc;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_pc    = RESET_PC;
    m_stale = 64'h0;
    m_drop  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_update();
    bit   req;
    bit   ack;
    ent_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    req = m_req();
    ack = req && imem_ack;
    if (redirect) begin
      if (!m_drop && req && !ack) begin
        m_drop  = 1'b1;
        m_stale = m_pc;
      end
      m_buf.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
    end else if (m_drop) begin
      if (ack) m_drop = 1'b0;
    end else begin
      if (m_buf.size() > 0 && id_ready) void'(m_buf.pop_front());
      if (ack) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        m_buf.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_req", {63'b0, imem_req}, {63'b0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("if_valid", {63'b0, if_valid}, {63'b0, (m_buf.size() > 0)});
    if (m_buf.size() > 0) begin
      chk("if_pc", if_pc, m_buf[0].pc);
      chk("if_instr", {32'b0, if_instr}, {32'b0, m_buf[0].instr});
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs, cross one rising edge, end just after the following falling edge.
  task automatic step(input bit ack, input bit rdy, input bit rd, input logic [63:0] rpc);
    imem_ack    = ack;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check its asynchronous effect, release mid-cycle.
  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_if_valid", {63'b0, if_valid}, 64'd0);
    chk("rst_imem_req", {63'b0, imem_req}, 64'd0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_instr", {32'b0, if_instr}, 64'h0);
    repeat (cycles) begin
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("first_req", {63'b0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rpc;
    int          ack_pct;
    int          rdy_pct;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    model_reset();
    @(negedge clk);
    #1;

    // Back-to-back fetches with ack every cycle.
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      chk("b2b_valid", {63'b0, if_valid}, 64'd1);
      chk("b2b_pc", if_pc, 64'(4 * k));
      chk("b2b_instr", {32'b0, if_instr}, {32'b0, mem_word(64'(4 * k))});
    end

    // Ack latency 3: address stable, one valid pulse per fetch.
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      chk("lat3_addr0", imem_addr, 64'(4 * k));
      step(1'b0, 1'b1, 1'b0, 64'h0);
      chk("lat3_addr1", imem_addr, 64'(4 * k));
      chk("lat3_novalid", {63'b0, if_valid}, 64'd0);
      step(1'b0, 1'b1, 1'b0, 64'h0);
      chk("lat3_addr2", imem_addr, 64'(4 * k));
      step(1'b1, 1'b1, 1'b0, 64'h0);
      chk("lat3_valid", {63'b0, if_valid}, 64'd1);
      chk("lat3_pc", if_pc, 64'(4 * k));
    end

    // Decode stalled for 5 cycles: slot + skid fill, request stops, then drains in order.
    do_reset(2);
    repeat (5) step(1'b1, 1'b0, 1'b0, 64'h0);
    chk("stall_pc", if_pc, 64'h0);
    chk("stall_valid", {63'b0, if_valid}, 64'd1);
    chk("stall_req", {63'b0, imem_req}, 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("drain_pc4", if_pc, 64'h4);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("drain_pc8", if_pc, 64'h8);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("drain_pc12", if_pc, 64'hC);

    // Redirect while the fetch at 8 is outstanding.
    do_reset(2);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b1, 64'h100);
    chk("drop_valid", {63'b0, if_valid}, 64'd0);
    chk("drop_addr", imem_addr, 64'h8);
    chk("drop_req", {63'b0, imem_req}, 64'd1);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    chk("drop_hold", imem_addr, 64'h8);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("drop_discard", {63'b0, if_valid}, 64'd0);
    chk("drop_newaddr", imem_addr, 64'h100);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("drop_tgt_pc", if_pc, 64'h100);

    // PC wrap and target alignment.
    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("wrap_pc_top", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr0", imem_addr, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("wrap_pc0", if_pc, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h103);
    chk("align_addr", imem_addr, 64'h100);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("align_pc", if_pc, 64'h100);

    // Reset while waiting with a full skid.
    do_reset(2);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    chk("wait_req", {63'b0, imem_req}, 64'd0);
    do_reset(1);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    chk("restart_pc", if_pc, RESET_PC);

    // Randomized traffic in phases of differing ack/ready density.
    for (int ph = 0; ph < 6; ph++) begin
      ack_pct = 20 + 15 * ph;
      rdy_pct = 90 - 12 * ph;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0)
          rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else
          rpc = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 299) == 0) begin
          imem_ack = ($urandom_range(0, 1) == 1);
          do_reset($urandom_range(1, 3));
        end
        step(($urandom_range(0, 99) < ack_pct), ($urandom_range(0, 99) < rdy_pct),
             ($urandom_range(0, 24) == 0), rpc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
